// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer:
// state/class enums, opcodes, bus-select bit positions and IR field slices.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsRtype, ClsImm, ClsLd, ClsSt, ClsNop, ClsHalt, ClsBad
  } ins_class_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned BUS_R0     = 0;
  localparam int unsigned BUS_HI     = 16;
  localparam int unsigned BUS_LO     = 17;
  localparam int unsigned BUS_ZHI    = 18;
  localparam int unsigned BUS_ZLO    = 19;
  localparam int unsigned BUS_PC     = 20;
  localparam int unsigned BUS_MDR    = 21;
  localparam int unsigned BUS_INPORT = 22;
  localparam int unsigned BUS_C      = 23;

  localparam int unsigned IR_OP_MSB = 31;
  localparam int unsigned IR_OP_LSB = 27;
  localparam int unsigned IR_RA_MSB = 26;
  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_MSB = 22;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_MSB = 18;
  localparam int unsigned IR_RC_LSB = 15;

endpackage

// File: rtl/ir_decode.sv
// Combinational instruction decode: opcode class, ALU operation and
// one-hot register-field selects.
module ir_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 16
) (
  input  logic [31:0]     ir,
  output ins_class_e      cls,
  output logic [4:0]      alu_op,
  output logic [NREG-1:0] ra_oh,
  output logic [NREG-1:0] rb_oh,
  output logic [NREG-1:0] rc_oh
);

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign op = ir[IR_OP_MSB:IR_OP_LSB];
  assign ra = ir[IR_RA_MSB:IR_RA_LSB];
  assign rb = ir[IR_RB_MSB:IR_RB_LSB];
  assign rc = ir[IR_RC_MSB:IR_RC_LSB];
  // Immediate/constant bits are consumed by the datapath, not the sequencer.
  assign unused_ir = ^ir[IR_RC_LSB-1:0];

  always_comb begin
    cls    = ClsBad;
    alu_op = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        cls    = ClsRtype;
        alu_op = op;
      end
      OP_LDI, OP_ADDI: begin
        cls    = ClsImm;
        alu_op = OP_ADD;
      end
      OP_ANDI: begin
        cls    = ClsImm;
        alu_op = OP_AND;
      end
      OP_ORI: begin
        cls    = ClsImm;
        alu_op = OP_OR;
      end
      OP_LD: begin
        cls    = ClsLd;
        alu_op = OP_ADD;
      end
      OP_ST: begin
        cls    = ClsSt;
        alu_op = OP_ADD;
      end
      OP_NOP:  cls = ClsNop;
      OP_HALT: cls = ClsHalt;
      default: cls = ClsBad;
    endcase

    ra_oh     = '0;
    rb_oh     = '0;
    rc_oh     = '0;
    ra_oh[ra] = 1'b1;
    rb_oh[rb] = 1'b1;
    rc_oh[rc] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-state sequencer for the single-bus DataPath: fetch, decode and
// execute with memory wait states via mem_ready.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned BUS_W = 24,
  parameter int unsigned NREG  = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [BUS_W-1:0] Bus_Encoder_signals,
  output logic [NREG-1:0]  Rin,
  output logic             PCin,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             RYin,
  output logic             RZin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Mem_read,
  output logic             Mem_write,
  output logic [4:0]       opcode,
  output logic             run,
  output logic             illegal
);

  state_e          state_q, state_d;
  logic            illegal_q, illegal_d;
  ins_class_e      cls;
  logic [4:0]      alu_op;
  logic [NREG-1:0] ra_oh, rb_oh, rc_oh;

  ir_decode #(
    .NREG(NREG)
  ) u_ir_decode (
    .ir    (ir),
    .cls   (cls),
    .alu_op(alu_op),
    .ra_oh (ra_oh),
    .rb_oh (rb_oh),
    .rc_oh (rc_oh)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StT0: state_d = StT1;
      StT1: if (mem_ready) state_d = StT2;
      StT2: state_d = StT3;
      StT3: begin
        case (cls)
          ClsNop:  state_d = StT0;
          ClsHalt: state_d = StHalt;
          ClsBad: begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end
          default: state_d = StT4;
        endcase
      end
      StT4: state_d = StT5;
      StT5: state_d = (cls inside {ClsLd, ClsSt}) ? StT6 : StT0;
      // Only the load read waits in T6; the store write waits in T7.
      StT6: if (cls != ClsLd || mem_ready) state_d = StT7;
      StT7: if (cls != ClsSt || mem_ready) state_d = StT0;
      StHalt: state_d = StHalt;
      default: state_d = StT0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= StT0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    Bus_Encoder_signals = '0;
    Rin       = '0;
    PCin      = 1'b0;
    IRin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    RYin      = 1'b0;
    RZin      = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IncPC     = 1'b0;
    Mem_read  = 1'b0;
    Mem_write = 1'b0;
    opcode    = '0;
    run       = 1'b1;
    illegal   = illegal_q;

    unique case (state_q)
      StT0: begin
        Bus_Encoder_signals[BUS_PC] = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        RZin  = 1'b1;
      end
      StT1: begin
        Bus_Encoder_signals[BUS_ZLO] = 1'b1;
        PCin     = 1'b1;
        Mem_read = 1'b1;
        MDRin    = 1'b1;
      end
      StT2: begin
        Bus_Encoder_signals[BUS_MDR] = 1'b1;
        IRin = 1'b1;
      end
      StT3: begin
        if (cls inside {ClsRtype, ClsImm, ClsLd, ClsSt}) begin
          Bus_Encoder_signals[BUS_R0 +: NREG] = rb_oh;
          RYin = 1'b1;
        end
      end
      StT4: begin
        if (cls == ClsRtype) begin
          Bus_Encoder_signals[BUS_R0 +: NREG] = rc_oh;
        end else begin
          Bus_Encoder_signals[BUS_C] = 1'b1;
        end
        RZin   = 1'b1;
        opcode = alu_op;
      end
      StT5: begin
        Bus_Encoder_signals[BUS_ZLO] = 1'b1;
        if (cls inside {ClsLd, ClsSt}) begin
          MARin = 1'b1;
        end else begin
          Rin = ra_oh;
        end
      end
      StT6: begin
        MDRin = 1'b1;
        if (cls == ClsSt) begin
          Bus_Encoder_signals[BUS_R0 +: NREG] = ra_oh;
        end else begin
          Mem_read = 1'b1;
        end
      end
      StT7: begin
        if (cls == ClsSt) begin
          Mem_write = 1'b1;
        end else begin
          Bus_Encoder_signals[BUS_MDR] = 1'b1;
          Rin = ra_oh;
        end
      end
      StHalt: run = 1'b0;
      default: run = 1'b1;
    endcase

    // Reset masks the decoded state so nothing is strobed while clear is held.
    if (clear) begin
      Bus_Encoder_signals = '0;
      Rin       = '0;
      PCin      = 1'b0;
      IRin      = 1'b0;
      MARin     = 1'b0;
      MDRin     = 1'b0;
      RYin      = 1'b0;
      RZin      = 1'b0;
      IncPC     = 1'b0;
      Mem_read  = 1'b0;
      Mem_write = 1'b0;
      opcode    = '0;
      run       = 1'b1;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, multi-cycle corner sequences,
// and random instructions checked against a per-instruction phase-list model.
module tb_control_unit;

  localparam int PCIN = 10, IRIN = 9, MARIN = 8, MDRIN = 7, RYIN = 6, RZIN = 5;
  localparam int INCPC = 2, MRD = 1, MWR = 0;
  localparam int K_R = 0, K_IMM = 1, K_LD = 2, K_ST = 3, K_NOP = 4, K_HALT = 5, K_BAD = 6;

  typedef struct packed {
    logic [23:0] bus;
    logic [15:0] rin;
    logic [10:0] fl;
    logic [4:0]  op;
    logic        run;
    logic        ill;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   waits;
  } phase_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          cyc;
    obs_t        exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic [23:0] bus;
  logic [15:0] rin;
  logic pc_in, ir_in, mar_in, mdr_in, ry_in, rz_in, hi_in, lo_in, inc_pc, mem_rd, mem_wr;
  logic [4:0]  alu;
  logic        run, illegal;

  int n_checks = 0;
  int n_pass   = 0;

  phase_t ph[$];
  vec_t   vt[$];

  control_unit #(
    .BUS_W(24),
    .NREG (16)
  ) dut (
    .clock              (clock),
    .clear              (clear),
    .ir                 (ir),
    .mem_ready          (mem_ready),
    .Bus_Encoder_signals(bus),
    .Rin                (rin),
    .PCin               (pc_in),
    .IRin               (ir_in),
    .MARin              (mar_in),
    .MDRin              (mdr_in),
    .RYin               (ry_in),
    .RZin               (rz_in),
    .HIin               (hi_in),
    .LOin               (lo_in),
    .IncPC              (inc_pc),
    .Mem_read           (mem_rd),
    .Mem_write          (mem_wr),
    .opcode             (alu),
    .run                (run),
    .illegal            (illegal)
  );

  always #5 clock = ~clock;

  function automatic logic [10:0] f(int b);
    logic [10:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] oh(int b);
    logic [15:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic obs_t rec(int bus_bit, logic [15:0] r, logic [10:0] fl, logic [4:0] op);
    obs_t o;
    o = '0;
    if (bus_bit >= 0) o.bus[bus_bit] = 1'b1;
    o.rin = r;
    o.fl  = fl;
    o.op  = op;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic obs_t halt_rec(logic ill);
    obs_t o;
    o     = '0;
    o.ill = ill;
    return o;
  endfunction

  function automatic obs_t clr_rec();
    obs_t o;
    o     = '0;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic obs_t t0_rec();
    return rec(20, 16'h0, f(MARIN) | f(INCPC) | f(RZIN), 5'd0);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.bus = bus;
    o.rin = rin;
    o.fl  = {pc_in, ir_in, mar_in, mdr_in, ry_in, rz_in, hi_in, lo_in, inc_pc, mem_rd, mem_wr};
    o.op  = alu;
    o.run = run;
    o.ill = illegal;
    return o;
  endfunction

  function automatic int kind_of(logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return K_R;
    if (op == 5'd1 || (op >= 5'd12 && op <= 5'd14)) return K_IMM;
    if (op == 5'd0) return K_LD;
    if (op == 5'd2) return K_ST;
    if (op == 5'd26) return K_NOP;
    if (op == 5'd27) return K_HALT;
    return K_BAD;
  endfunction

  function automatic logic [4:0] alu_of(logic [4:0] op);
    if (kind_of(op) == K_R) return op;
    if (op == 5'd13) return 5'b00101;
    if (op == 5'd14) return 5'b00110;
    return 5'b00011;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    #1;
    act = sample();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got bus=%06h rin=%04h fl=%011b op=%05b run=%b ill=%b; want bus=%06h rin=%04h fl=%011b op=%05b run=%b ill=%b",
                  name, act.bus, act.rin, act.fl, act.op, act.run, act.ill,
                  exp.bus, exp.rin, exp.fl, exp.op, exp.run, exp.ill);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Entered and left just after a negedge; on return the current cycle is T0.
  task automatic do_clear();
    clear     = 1'b1;
    mem_ready = 1'b1;
    check_obs("clear", clr_rec());
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic push(input obs_t o, input bit w);
    phase_t p;
    p.o     = o;
    p.waits = w;
    ph.push_back(p);
  endtask

  // Expected per-cycle outputs of one instruction, one phase per T-state.
  task automatic build(input logic [31:0] i, output int k);
    logic [4:0] op;
    int ra, rb, rc;
    op = i[31:27];
    ra = int'(i[26:23]);
    rb = int'(i[22:19]);
    rc = int'(i[18:15]);
    ph.delete();
    push(t0_rec(), 1'b0);
    push(rec(19, 16'h0, f(PCIN) | f(MRD) | f(MDRIN), 5'd0), 1'b1);
    push(rec(21, 16'h0, f(IRIN), 5'd0), 1'b0);
    k = kind_of(op);
    if (k >= K_NOP) begin
      push(rec(-1, 16'h0, 11'h0, 5'd0), 1'b0);
      return;
    end
    push(rec(rb, 16'h0, f(RYIN), 5'd0), 1'b0);
    push(rec((k == K_R) ? rc : 23, 16'h0, f(RZIN), alu_of(op)), 1'b0);
    if (k == K_R || k == K_IMM) push(rec(19, oh(ra), 11'h0, 5'd0), 1'b0);
    else push(rec(19, 16'h0, f(MARIN), 5'd0), 1'b0);
    if (k == K_LD) begin
      push(rec(-1, 16'h0, f(MRD) | f(MDRIN), 5'd0), 1'b1);
      push(rec(21, oh(ra), 11'h0, 5'd0), 1'b0);
    end
    if (k == K_ST) begin
      push(rec(ra, 16'h0, f(MDRIN), 5'd0), 1'b0);
      push(rec(-1, 16'h0, f(MWR), 5'd0), 1'b1);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] i, input int cyc, input obs_t e);
    vec_t v;
    v.name = name;
    v.ir   = i;
    v.cyc  = cyc;
    v.exp  = e;
    vt.push_back(v);
  endtask

  initial begin
    logic [4:0]  legal [15];
    logic [4:0]  op;
    logic [31:0] rnd;
    int k, hi, idx, stall;
    bit mr;

    clear     = 1'b1;
    ir        = '0;
    mem_ready = 1'b1;
    @(negedge clock);
    check_obs("reset", clr_rec());

    add_vec("and_t3",   32'h28918000, 4, rec(2, 16'h0, f(RYIN), 5'd0));
    add_vec("and_t4",   32'h28918000, 5, rec(3, 16'h0, f(RZIN), 5'b00101));
    add_vec("and_t5",   32'h28918000, 6, rec(19, 16'h0002, 11'h0, 5'd0));
    add_vec("and_t0",   32'h28918000, 7, t0_rec());
    add_vec("t1_fetch", 32'h28918000, 2, rec(19, 16'h0, f(PCIN) | f(MRD) | f(MDRIN), 5'd0));
    add_vec("t2_fetch", 32'h28918000, 3, rec(21, 16'h0, f(IRIN), 5'd0));
    add_vec("nop_t3",   32'hD0000000, 4, rec(-1, 16'h0, 11'h0, 5'd0));
    add_vec("nop_t0",   32'hD0000000, 5, t0_rec());
    add_vec("ld_t5",    32'h00800000, 6, rec(19, 16'h0, f(MARIN), 5'd0));
    add_vec("ld_t6",    32'h00800000, 7, rec(-1, 16'h0, f(MRD) | f(MDRIN), 5'd0));
    add_vec("ld_t7",    32'h00800000, 8, rec(21, 16'h0002, 11'h0, 5'd0));
    add_vec("st_t6",    32'h10800000, 7, rec(1, 16'h0, f(MDRIN), 5'd0));
    add_vec("st_t7",    32'h10800000, 8, rec(-1, 16'h0, f(MWR), 5'd0));
    add_vec("st_t0",    32'h10800000, 9, t0_rec());
    add_vec("ldi_t4",   32'h08800000, 5, rec(23, 16'h0, f(RZIN), 5'b00011));
    add_vec("ldi_t5",   32'h08800000, 6, rec(19, 16'h0002, 11'h0, 5'd0));
    add_vec("addi_t4",  32'h60000000, 5, rec(23, 16'h0, f(RZIN), 5'b00011));
    add_vec("andi_t4",  32'h68000000, 5, rec(23, 16'h0, f(RZIN), 5'b00101));
    add_vec("ori_t4",   32'h70000000, 5, rec(23, 16'h0, f(RZIN), 5'b00110));
    add_vec("shra_t4",  32'h50000000, 5, rec(0, 16'h0, f(RZIN), 5'b01010));
    add_vec("halt_t4",  32'hD8000000, 5, halt_rec(1'b0));
    add_vec("bad_t4",   32'hF8000000, 5, halt_rec(1'b1));

    foreach (vt[i]) begin
      do_clear();
      ir        = vt[i].ir;
      mem_ready = 1'b1;
      repeat (vt[i].cyc - 1) @(negedge clock);
      check_obs(vt[i].name, vt[i].exp);
    end

    // ld with three wait cycles in T6
    do_clear();
    ir = 32'h00800000;
    repeat (6) @(negedge clock);
    hi = 0;
    for (int j = 0; j < 4; j++) begin
      mem_ready = (j == 3);
      #1;
      if (mem_rd && mdr_in) hi++;
      @(negedge clock);
    end
    check_val("ld_wait_strobes", hi, 4);
    check_obs("ld_wait_t7", rec(21, 16'h0002, 11'h0, 5'd0));

    // st waiting in T7
    do_clear();
    ir = 32'h10800000;
    repeat (6) @(negedge clock);
    check_obs("stw_t6", rec(1, 16'h0, f(MDRIN), 5'd0));
    @(negedge clock);
    for (int j = 0; j < 3; j++) begin
      mem_ready = (j == 2);
      check_obs("stw_t7", rec(-1, 16'h0, f(MWR), 5'd0));
      @(negedge clock);
    end
    check_obs("stw_t0", t0_rec());

    // halt holds for 20 cycles, then clear restarts at T0
    do_clear();
    ir = 32'hD8000000;
    repeat (3) @(negedge clock);
    check_obs("halt_t3", rec(-1, 16'h0, 11'h0, 5'd0));
    for (int j = 0; j < 20; j++) begin
      @(negedge clock);
      check_obs("halt_hold", halt_rec(1'b0));
    end
    @(negedge clock);
    do_clear();
    check_obs("halt_restart", t0_rec());

    // illegal opcode is sticky until clear
    ir = 32'hF8000000;
    repeat (4) @(negedge clock);
    check_obs("illegal_set", halt_rec(1'b1));
    @(negedge clock);
    check_obs("illegal_sticky", halt_rec(1'b1));
    @(negedge clock);
    do_clear();
    check_obs("illegal_cleared", t0_rec());

    // clear asserted during T4 of an add
    do_clear();
    ir = 32'h18918000;
    repeat (4) @(negedge clock);
    check_obs("add_t4", rec(3, 16'h0, f(RZIN), 5'b00011));
    clear = 1'b1;
    @(negedge clock);
    check_obs("clr_mid_next", clr_rec());
    clear = 1'b0;
    check_obs("clr_mid_t0", t0_rec());

    // random instruction stream with random memory wait states
    legal = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
              5'd11, 5'd12, 5'd13, 5'd14};
    @(negedge clock);
    do_clear();
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 19);
      if (k < 15) op = legal[k];
      else if (k < 17) op = 5'd26;
      else if (k == 17) op = 5'd27;
      else op = 5'($urandom_range(0, 31));
      rnd = $urandom();
      ir  = {op, rnd[26:0]};
      build(ir, k);
      idx   = 0;
      stall = 0;
      while (idx < ph.size()) begin
        mr        = ($urandom_range(0, 3) != 0) || (stall >= 4);
        mem_ready = mr;
        check_obs($sformatf("rand%0d_p%0d", n, idx), ph[idx].o);
        @(negedge clock);
        if (ph[idx].waits && !mr) stall++;
        else begin
          idx++;
          stall = 0;
        end
      end
      if (k == K_HALT || k == K_BAD) begin
        repeat (3) begin
          check_obs($sformatf("rand%0d_halt", n), halt_rec(k == K_BAD));
          @(negedge clock);
        end
        do_clear();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
